// File: rtl/tm1638_key_reader_if.sv
// Pin/handshake bundle for tm1638_key_reader: scan request, shared TM1638 pins and decoded key results.
interface tm1638_key_reader_if;
  localparam int unsigned RAW_W = 32;
  localparam int unsigned KEY_W = 8;

  logic             start;
  logic             busy;
  logic             stb;
  logic             tm_clk;
  logic             dio_out;
  logic             dio_oe;
  logic             dio_in;
  logic [RAW_W-1:0] raw_data;
  logic [KEY_W-1:0] keys;
  logic             key_valid;

  modport slave (
    input  start, dio_in,
    output busy, stb, tm_clk, dio_out, dio_oe, raw_data, keys, key_valid
  );

  modport master (
    output start, dio_in,
    input  busy, stb, tm_clk, dio_out, dio_oe, raw_data, keys, key_valid
  );
endinterface

// File: rtl/tm1638_key_reader.sv
// TM1638 key scanner: issues command 0x42, reads 4 key bytes LSB-first and publishes the decoded 8 keys.
// Optional build macro KEY_DEBOUNCE_EN: keys only update when two consecutive scans decode identically.
module tm1638_key_reader #(
  parameter int unsigned CLK_DIV  = 50,
  parameter int unsigned WAIT_CYC = 200,
  parameter int unsigned GAP_CYC  = 100
) (
  input logic                 clk,
  input logic                 rst,
  tm1638_key_reader_if.slave  bus
);

  localparam int unsigned MAX_A   = (CLK_DIV > WAIT_CYC) ? CLK_DIV : WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned RAW_W   = 32;
  localparam int unsigned KEY_W   = 8;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(7);
  localparam logic [BIT_W-1:0] READ_LAST = BIT_W'(31);
  localparam logic [7:0]       CMD_READ  = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_WAIT, S_READ, S_DONE, S_GAP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [7:0]         cmd_sr;
  logic [RAW_W-1:0]   rx_sr;
  logic               din_meta;
  logic               din_sync;
  logic               stb;
  logic               tm_clk;
  logic               dio_out;
  logic               dio_oe;
  logic               busy;
  logic [RAW_W-1:0]   raw_data;
  logic [KEY_W-1:0]   keys;
  logic               key_valid;
  logic [KEY_W-1:0]   scan_keys_c;
`ifdef KEY_DEBOUNCE_EN
  logic [KEY_W-1:0]   prev_keys;
  logic               prev_vld;
`endif

  assign bus.stb       = stb;
  assign bus.tm_clk    = tm_clk;
  assign bus.dio_out   = dio_out;
  assign bus.dio_oe    = dio_oe;
  assign bus.busy      = busy;
  assign bus.raw_data  = raw_data;
  assign bus.keys      = keys;
  assign bus.key_valid = key_valid;

  // Key i lives in bit0 of byte i, key i+4 in bit4 of byte i.
  always_comb begin
    scan_keys_c = '0;
    for (int i = 0; i < 4; i++) begin
      scan_keys_c[i]     = rx_sr[8*i];
      scan_keys_c[i + 4] = rx_sr[8*i + 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_meta <= 1'b0;
      din_sync <= 1'b0;
    end else begin
      din_meta <= bus.dio_in;
      din_sync <= din_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      rx_sr     <= '0;
      stb       <= 1'b1;
      tm_clk    <= 1'b1;
      dio_out   <= 1'b1;
      dio_oe    <= 1'b0;
      busy      <= 1'b0;
      raw_data  <= '0;
      keys      <= '0;
      key_valid <= 1'b0;
`ifdef KEY_DEBOUNCE_EN
      prev_keys <= '0;
      prev_vld  <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_SETUP;
            stb     <= 1'b0;
            busy    <= 1'b1;
            dio_oe  <= 1'b1;
            dio_out <= 1'b1;
            cnt     <= '0;
            cmd_sr  <= CMD_READ;
          end
        end
        S_SETUP: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            state   <= S_CMD;
            cnt     <= '0;
            bit_cnt <= '0;
            tm_clk  <= 1'b0;
            dio_out <= cmd_sr[0];
            cmd_sr  <= {1'b0, cmd_sr[7:1]};
          end
        end
        // Data only moves on the falling edge; the chip latches on the rising edge.
        S_CMD: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (!tm_clk) begin
              tm_clk <= 1'b1;
            end else if (bit_cnt == CMD_LAST) begin
              state  <= S_WAIT;
              dio_oe <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tm_clk  <= 1'b0;
              dio_out <= cmd_sr[0];
              cmd_sr  <= {1'b0, cmd_sr[7:1]};
            end
          end
        end
        S_WAIT: begin
          if (cnt != WAIT_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            state   <= S_READ;
            cnt     <= '0;
            bit_cnt <= '0;
            tm_clk  <= 1'b0;
          end
        end
        // Sample at the very end of the high phase to give the synchronizer the full half period.
        S_READ: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (!tm_clk) begin
              tm_clk <= 1'b1;
            end else begin
              rx_sr <= {din_sync, rx_sr[RAW_W-1:1]};
              if (bit_cnt == READ_LAST) begin
                state <= S_DONE;
                stb   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                tm_clk  <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          state    <= S_GAP;
          cnt      <= '0;
          raw_data <= rx_sr;
`ifdef KEY_DEBOUNCE_EN
          if (prev_vld && (scan_keys_c == prev_keys)) begin
            keys      <= scan_keys_c;
            key_valid <= 1'b1;
          end
          prev_keys <= scan_keys_c;
          prev_vld  <= 1'b1;
`else
          keys      <= scan_keys_c;
          key_valid <= 1'b1;
`endif
        end
        S_GAP: begin
          if (cnt != GAP_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Self-checking bench for tm1638_key_reader with an event-driven TM1638 pin model and a key-state reference model.
module tb_tm1638_key_reader;
  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned WAIT_CYC = 4;
  localparam int unsigned GAP_CYC  = 4;
  localparam int LAT    = 1 + 81 * CLK_DIV + WAIT_CYC;
  localparam int BUDGET = LAT + GAP_CYC + 40;
`ifdef KEY_DEBOUNCE_EN
  localparam bit DEBOUNCE = 1'b1;
`else
  localparam bit DEBOUNCE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  tm1638_key_reader_if bus ();

  tm1638_key_reader #(.CLK_DIV(CLK_DIV), .WAIT_CYC(WAIT_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // TM1638 pin model: latches command bits on rising tm_clk, drives key bits after falling tm_clk.
  logic [31:0] model_data = '0;
  logic [7:0]  cmd_byte   = '0;
  int          ncmd       = 0;
  int          nrd        = 0;
  int          rd_idx     = 0;
  logic        prev_stb   = 1'b1;
  logic        prev_clk   = 1'b1;

  initial begin
    bus.start  = 1'b0;
    bus.dio_in = 1'b0;
  end

  always @(bus.stb or bus.tm_clk) begin
    if (prev_stb === 1'b1 && bus.stb === 1'b0) begin
      ncmd = 0; nrd = 0; rd_idx = 0; cmd_byte = '0;
    end
    if (bus.stb === 1'b0 && prev_clk === 1'b0 && bus.tm_clk === 1'b1) begin
      if (bus.dio_oe === 1'b1) begin
        cmd_byte = {bus.dio_out, cmd_byte[7:1]};
        ncmd++;
      end else begin
        nrd++;
      end
    end
    if (bus.stb === 1'b0 && prev_clk === 1'b1 && bus.tm_clk === 1'b0 && bus.dio_oe === 1'b0) begin
      if (rd_idx < 32) bus.dio_in = model_data[rd_idx];
      rd_idx++;
    end
    prev_stb = bus.stb;
    prev_clk = bus.tm_clk;
  end

  // Reference model of the published key state.
  logic [7:0] m_keys      = '0;
  logic [7:0] m_prev      = '0;
  bit         m_have_prev = 1'b0;

  function automatic logic [7:0] decode(input logic [31:0] d);
    logic [7:0] k;
    logic [7:0] b;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      b = d[8*i +: 8];
      k[i]     = b[0];
      k[i + 4] = b[4];
    end
    return k;
  endfunction

  task automatic model_scan(input logic [7:0] dec, output bit v);
    if (DEBOUNCE) begin
      v = m_have_prev && (dec == m_prev);
      m_prev = dec;
      m_have_prev = 1'b1;
    end else begin
      v = 1'b1;
    end
    if (v) m_keys = dec;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stb"},       32'(bus.stb), 1);
    check({tag, "_tm_clk"},    32'(bus.tm_clk), 1);
    check({tag, "_dio_out"},   32'(bus.dio_out), 1);
    check({tag, "_dio_oe"},    32'(bus.dio_oe), 0);
    check({tag, "_busy"},      32'(bus.busy), 0);
    check({tag, "_raw"},       bus.raw_data, 0);
    check({tag, "_keys"},      32'(bus.keys), 0);
    check({tag, "_key_valid"}, 32'(bus.key_valid), 0);
  endtask

  // One complete scan; n counts clk edges after the edge that samples start.
  task automatic run_scan(input string tag, input logic [31:0] data, input logic [7:0] dec,
                          input int poke_at);
    int n, kv_cycle, kv_cnt, stb_rise;
    bit exp_v;
    model_data = data;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    n = 0; kv_cycle = -1; kv_cnt = 0; stb_rise = -1;
    while (n < BUDGET) begin
      @(posedge clk); n++; #1;
      bus.start = (n == poke_at);
      if (bus.key_valid) begin
        kv_cnt++;
        if (kv_cycle < 0) kv_cycle = n;
      end
      if (stb_rise < 0 && bus.stb) stb_rise = n;
      if (!bus.busy) break;
    end
    bus.start = 1'b0;
    model_scan(dec, exp_v);
    check({tag, "_cmd_edges"}, 32'(ncmd), 8);
    check({tag, "_cmd_byte"},  32'(cmd_byte), 32'h42);
    check({tag, "_read_edges"}, 32'(nrd), 32);
    check({tag, "_stb_rise"},  32'(stb_rise), 32'(LAT - 1));
    check({tag, "_kv_cycle"},  32'(kv_cycle), exp_v ? 32'(LAT) : 32'hFFFF_FFFF);
    check({tag, "_kv_count"},  32'(kv_cnt), exp_v ? 1 : 0);
    check({tag, "_busy_end"},  32'(n), 32'(LAT + GAP_CYC));
    check({tag, "_raw"},       bus.raw_data, data);
    check({tag, "_keys"},      32'(bus.keys), 32'(m_keys));
  endtask

  typedef struct {
    logic [31:0] data;
    logic [7:0]  exp_keys;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, rise, fall, quiet;
    bit saw_low, v;
    logic [31:0] d, last_d;

    vecs[0] = '{32'h0010_0001, 8'h41};
    vecs[1] = '{32'h0000_0000, 8'h00};
    vecs[2] = '{32'hFFFF_FFFF, 8'hFF};
    vecs[3] = '{32'h1010_1010, 8'hF0};
    vecs[4] = '{32'h0101_0101, 8'h0F};
    vecs[5] = '{32'h0011_0000, 8'h44};
    vecs[6] = '{32'h1000_0001, 8'h81};
    vecs[7] = '{32'hEEEE_EEEE, 8'h00};

    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    #20;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven scans.
    for (int i = 0; i < 8; i++)
      run_scan($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_keys, -1);

    // Debounce pair: two identical scans in a row.
    run_scan("pair_a", 32'h0010_0001, 8'h41, -1);
    run_scan("pair_b", 32'h0010_0001, 8'h41, -1);

    // start pulsed mid-scan must not queue a second scan.
    run_scan("poke", 32'h0000_1000, 8'h20, 20);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bus.stb || bus.busy) quiet++;
    end
    check("poke_no_extra_scan", 32'(quiet), 0);

    // start held high: back-to-back scans separated by DONE + GAP + one IDLE sample cycle.
    model_data = 32'h0100_0010;
    n = 0; rise = -1; fall = -1; saw_low = 1'b0;
    @(negedge clk) bus.start = 1'b1;
    while (n < 2 * BUDGET && fall < 0) begin
      @(posedge clk); n++; #1;
      if (rise < 0 && !bus.stb) saw_low = 1'b1;
      else if (rise < 0 && bus.stb && saw_low) rise = n;
      else if (rise >= 0 && !bus.stb) fall = n;
    end
    bus.start = 1'b0;
    check("hold_first_rise", 32'(rise), 32'(LAT));
    check("hold_gap", 32'(fall - rise), 32'(GAP_CYC + 2));
    n = 0;
    while (n < 2 * BUDGET && bus.busy) begin
      @(posedge clk); n++; #1;
    end
    model_scan(decode(32'h0100_0010), v);
    model_scan(decode(32'h0100_0010), v);
    check("hold_busy_done", 32'(bus.busy), 0);
    check("hold_raw", bus.raw_data, 32'h0100_0010);
    check("hold_keys", 32'(bus.keys), 32'(m_keys));

    // Randomized scans against the reference model; some repeats to exercise debounce.
    last_d = 32'h0;
    for (int i = 0; i < 14; i++) begin
      d = ($urandom_range(0, 3) == 0) ? last_d : $urandom;
      run_scan($sformatf("rnd%0d", i), d, decode(d), -1);
      last_d = d;
    end

    // Make sure keys are non-zero before aborting.
    run_scan("pre_abort_a", 32'h0010_0001, 8'h41, -1);
    run_scan("pre_abort_b", 32'h0010_0001, 8'h41, -1);

    // Abort during READ bit 10.
    model_data = 32'h5A5A_A5A5;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (17 * CLK_DIV + WAIT_CYC + 20 * CLK_DIV + CLK_DIV) @(posedge clk);
    #1;
    check("abort_in_read", {30'b0, bus.stb, bus.dio_oe}, 0);
    check("abort_read_edges", 32'(nrd), 11);
    #1 rst = 1'b1;
    #1 check_reset_outputs("abort");
    m_keys = '0; m_prev = '0; m_have_prev = 1'b0;
    @(negedge clk) rst = 1'b0;
    run_scan("post_abort_a", 32'h0010_0001, 8'h41, -1);
    run_scan("post_abort_b", 32'h0010_0001, 8'h41, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
